// File: rtl/mimc_feistel_inverse_round.sv
// Inverse of one MiMC Feistel round over the BN254 scalar field.
// A sequential FSM computes x = L + k + c, then x^2, x^4 and x^5 on one shared
// shift-and-add modular multiplier, then subtracts x^5 from the other word.

// MSB-first double-and-add modular multiplier; one multiplier bit per cycle.
module mimc_feistel_inverse_round_mul #(
  parameter int N_BITS = 254,
  parameter logic [N_BITS-1:0] MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] prod
);
  localparam int CW = $clog2(N_BITS + 1);

  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] areg;
  logic [N_BITS-1:0] breg;
  logic [CW-1:0]     cnt;
  logic [N_BITS-1:0] dbl;
  logic [N_BITS-1:0] step;

  function automatic logic [N_BITS-1:0] add_mod(input logic [N_BITS-1:0] x, input logic [N_BITS-1:0] y);
    logic [N_BITS:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, MODULUS}) s = s - {1'b0, MODULUS};
    return s[N_BITS-1:0];
  endfunction

  // One double-and-add step: acc = 2*acc (+ a when the current b bit is set).
  always_comb begin
    dbl  = add_mod(acc, acc);
    step = dbl;
    if (breg[N_BITS-1]) step = add_mod(dbl, areg);
  end

  // Operand load, iteration counter and one-cycle done pulse; clear abandons a product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      areg <= '0;
      breg <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        acc  <= '0;
        areg <= a;
        breg <= b;
        cnt  <= CW'(N_BITS);
        busy <= 1'b1;
      end else if (busy) begin
        acc  <= step;
        breg <= {breg[N_BITS-2:0], 1'b0};
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod = acc;
endmodule

// Top level: capture, add, three multiplications, subtract, hold result.
module mimc_feistel_inverse_round #(
  parameter int N_BITS = 254,
  parameter string GALOIS_MULT_METHOD = "peasant",
  parameter logic [N_BITS-1:0] MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_BITS-1:0] in_left,
  input  logic [N_BITS-1:0] in_right,
  input  logic [N_BITS-1:0] round_constant,
  input  logic [N_BITS-1:0] key,
  input  logic              is_last_round,
  output logic [N_BITS-1:0] out_left,
  output logic [N_BITS-1:0] out_right,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, ADD, SQ, QUAD, QUINT, SUB, DONE} state_t;

  state_t state, nxt;

  logic [N_BITS-1:0] l_r, r_r, k_r, c_r, x_r, pw_r;
  logic              last_r;
  logic              mul_start, mul_busy, mul_done, mul_clear;
  logic [N_BITS-1:0] mul_a, mul_b, mul_prod;

  function automatic logic [N_BITS-1:0] add_mod(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, MODULUS}) s = s - {1'b0, MODULUS};
    return s[N_BITS-1:0];
  endfunction

  function automatic logic [N_BITS-1:0] sub_mod(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
    logic [N_BITS:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, MODULUS};
    return d[N_BITS-1:0];
  endfunction

  // An abandoned product is flushed while idle so a new run never sees a stale done.
  assign mul_clear = (state == IDLE);

  // Only the shift-and-add method exists; any other selection falls back to it.
  if (GALOIS_MULT_METHOD == "peasant") begin : g_peasant
    mimc_feistel_inverse_round_mul #(.N_BITS(N_BITS), .MODULUS(MODULUS)) u_mul (
      .clk(clk), .rst(rst), .clear(mul_clear), .start(mul_start),
      .a(mul_a), .b(mul_b), .busy(mul_busy), .done(mul_done), .prod(mul_prod)
    );
  end else begin : g_fallback
    mimc_feistel_inverse_round_mul #(.N_BITS(N_BITS), .MODULUS(MODULUS)) u_mul (
      .clk(clk), .rst(rst), .clear(mul_clear), .start(mul_start),
      .a(mul_a), .b(mul_b), .busy(mul_busy), .done(mul_done), .prod(mul_prod)
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next state, multiplier start and operand selection; en low aborts any busy state.
  always_comb begin
    nxt       = state;
    mul_start = 1'b0;
    mul_a     = x_r;
    mul_b     = x_r;
    case (state)
      IDLE:  if (en) nxt = ADD;
      ADD:   nxt = en ? SQ : IDLE;
      SQ: begin
        mul_start = en && !mul_busy && !mul_done;
        if (!en)          nxt = IDLE;
        else if (mul_done) nxt = QUAD;
      end
      QUAD: begin
        mul_a     = pw_r;
        mul_b     = pw_r;
        mul_start = en && !mul_busy && !mul_done;
        if (!en)          nxt = IDLE;
        else if (mul_done) nxt = QUINT;
      end
      QUINT: begin
        mul_a     = pw_r;
        mul_b     = x_r;
        mul_start = en && !mul_busy && !mul_done;
        if (!en)          nxt = IDLE;
        else if (mul_done) nxt = SUB;
      end
      SUB:   nxt = en ? DONE : IDLE;
      DONE:  if (!en) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: input capture, x, running power of x, output registers and done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_r       <= '0;
      r_r       <= '0;
      k_r       <= '0;
      c_r       <= '0;
      last_r    <= 1'b0;
      x_r       <= '0;
      pw_r      <= '0;
      out_left  <= '0;
      out_right <= '0;
      done      <= 1'b0;
    end else begin
      done <= (nxt == DONE);
      case (state)
        IDLE: if (en) begin
          l_r    <= in_left;
          r_r    <= in_right;
          k_r    <= key;
          c_r    <= round_constant;
          last_r <= is_last_round;
        end
        ADD: x_r <= add_mod(add_mod(last_r ? l_r : r_r, k_r), c_r);
        SQ, QUAD, QUINT: if (mul_done) pw_r <= mul_prod;
        SUB: if (en) begin
          if (last_r) begin
            out_left  <= l_r;
            out_right <= sub_mod(r_r, pw_r);
          end else begin
            out_left  <= r_r;
            out_right <= sub_mod(l_r, pw_r);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mimc_feistel_inverse_round.sv
// Bench for mimc_feistel_inverse_round: directed vectors, abort, reset
// mid-operation and a randomized round trip through a forward-round model.
module tb_mimc_feistel_inverse_round;
  localparam int N = 254;
  localparam logic [N-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam int T_MUL   = N + 2;
  localparam int EXP_LAT = 3 + 3 * T_MUL;
  localparam int BUDGET  = EXP_LAT + 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] in_left, in_right, round_constant, key;
  logic         is_last_round;
  logic [N-1:0] out_left, out_right;
  logic         done;

  int checks = 0;
  int errors = 0;

  mimc_feistel_inverse_round dut (
    .clk(clk), .rst(rst), .en(en),
    .in_left(in_left), .in_right(in_right),
    .round_constant(round_constant), .key(key),
    .is_last_round(is_last_round),
    .out_left(out_left), .out_right(out_right), .done(done)
  );

  always #5 clk = ~clk;

  // Reference field arithmetic using plain wide integer operators.
  function automatic logic [N-1:0] fadd(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [255:0] s;
    s = (256'(a) + 256'(b)) % 256'(P);
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [511:0] t;
    t = (512'(a) * 512'(b)) % 512'(P);
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] round_f(input logic [N-1:0] x, input logic [N-1:0] k, input logic [N-1:0] c);
    logic [N-1:0] y;
    y = fadd(fadd(x, k), c);
    return fmul(fmul(fmul(y, y), fmul(y, y)), y);
  endfunction

  function automatic logic [N-1:0] rand_fe();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    v[255:254] = 2'b00;
    v = v % 256'(P);
    return v[N-1:0];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for done, counting edges from the capture edge; scrambles inputs after capture.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        in_left = rand_fe(); in_right = rand_fe();
        key = rand_fe(); round_constant = rand_fe();
        is_last_round = ~is_last_round;
      end
      if (done) break;
    end
  endtask

  task automatic drive(input logic last, input logic [N-1:0] l, input logic [N-1:0] r,
                       input logic [N-1:0] k, input logic [N-1:0] c);
    @(negedge clk);
    is_last_round = last; in_left = l; in_right = r; key = k; round_constant = c;
    en = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic last, input logic [N-1:0] l, input logic [N-1:0] r,
                        input logic [N-1:0] k, input logic [N-1:0] c,
                        input logic [N-1:0] exp_l, input logic [N-1:0] exp_r);
    int lat;
    drive(last, l, r, k, c);
    wait_done(lat);
    check({tag, "_lat"}, 256'(lat), 256'(EXP_LAT));
    check({tag, "_left"}, 256'(out_left), 256'(exp_l));
    check({tag, "_right"}, 256'(out_right), 256'(exp_r));
  endtask

  // Drops en after done and confirms done clears while outputs are retained.
  task automatic end_op(input string tag, input logic [N-1:0] exp_l, input logic [N-1:0] exp_r);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_clr"}, 256'(done), 256'(0));
    check({tag, "_keep"}, {out_left, out_right}, {exp_l, exp_r});
  endtask

  initial begin
    int lat;
    logic [N-1:0] pl, pr, k, c, cl, cr;
    logic last;

    // Reset held with the first vector already requested.
    rst = 1'b0; en = 1'b1;
    is_last_round = 1'b1; in_left = 254'd1; in_right = 254'd40; key = '0; round_constant = 254'd1;
    repeat (3) @(negedge clk);
    check("rst_left", 256'(out_left), 256'(0));
    check("rst_right", 256'(out_right), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    rst = 1'b1;
    wait_done(lat);
    check("last_lat", 256'(lat), 256'(EXP_LAT));
    check("last_out", {out_left, out_right}, {254'd1, 254'd8});
    // done held while en stays high
    repeat (3) @(posedge clk);
    #1;
    check("last_hold", 256'(done), 256'(1));
    end_op("last", 254'd1, 254'd8);

    run_op("subwrap", 1'b0, 254'd35, 254'd3, '0, '0, 254'd3, P - 254'd208);
    end_op("subwrap", 254'd3, P - 254'd208);

    run_op("addwrap", 1'b0, 254'd5, P - 254'd1, 254'd1, '0, P - 254'd1, 254'd5);
    end_op("addwrap", P - 254'd1, 254'd5);

    // Abort during SQ, then rerun the last-round vector.
    drive(1'b1, 254'd1, 254'd40, '0, 254'd1);
    repeat (10) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort_done", 256'(done), 256'(0));
    end
    check("abort_keep", {out_left, out_right}, {P - 254'd1, 254'd5});
    run_op("reabort", 1'b1, 254'd1, 254'd40, '0, 254'd1, 254'd1, 254'd8);
    end_op("reabort", 254'd1, 254'd8);

    // Reset asserted during QUAD.
    drive(1'b0, 254'd35, 254'd3, '0, '0);
    repeat (2 + T_MUL + 20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("qrst_out", {out_left, out_right}, 508'(0));
    check("qrst_done", 256'(done), 256'(0));
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("postrst", 1'b0, 254'd35, 254'd3, '0, '0, 254'd3, P - 254'd208);
    end_op("postrst", 254'd3, P - 254'd208);

    // Round trip through the forward round.
    for (int i = 0; i < 100; i++) begin
      pl = rand_fe(); pr = rand_fe(); k = rand_fe(); c = rand_fe();
      last = 1'(i % 2);
      if (last) begin
        cl = pl;
        cr = fadd(pr, round_f(pl, k, c));
      end else begin
        cl = fadd(pr, round_f(pl, k, c));
        cr = pl;
      end
      run_op("rt", last, cl, cr, k, c, pl, pr);
      end_op("rt", pl, pr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
